// File: rtl/sd_block_server.sv
// Host-side responder for the sd_rd/sd_wr block handshake, backed by a byte-wide req/ready memory port.
// Optional: define SD_TRACE_EN for per-transfer trace prints under SIMULATION.
module sd_block_server #(
    parameter int VDNUM     = 3,
    parameter int BLK_BITS  = 9,
    parameter int ACK_DELAY = 4,
    parameter int GAP       = 2
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [32*VDNUM-1:0]     sd_lba_flat,
    input  logic [VDNUM-1:0]        sd_rd,
    input  logic [VDNUM-1:0]        sd_wr,
    output logic [VDNUM-1:0]        sd_ack,
    output logic [BLK_BITS-1:0]     sd_buff_addr,
    output logic [7:0]              sd_buff_dout,
    output logic                    sd_buff_wr,
    input  logic [8*VDNUM-1:0]      sd_buff_din_flat,
    output logic [VDNUM-1:0]        img_mounted,
    output logic [63:0]             img_size,
    output logic                    img_readonly,
    input  logic                    mount_stb,
    input  logic [3:0]              mount_drive,
    input  logic [63:0]             mount_size,
    input  logic                    mount_ro,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [3:0]              mem_drive,
    output logic [32+BLK_BITS-1:0]  mem_addr,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    input  logic                    mem_ready
);

    typedef enum logic [3:0] {
        IDLE, ACK_WAIT, RD_FETCH, RD_PUSH, WR_ADDR, WR_SAMPLE, WR_STORE, DONE, GAP_WAIT
    } state_t;

    typedef struct packed {
        logic [3:0]  drv;
        logic [31:0] lba;
        logic        rd;
        logic        valid;
        logic        ro;
    } req_t;

    state_t                    state;
    req_t                      cur;
    req_t                      arb;
    logic                      arb_hit;
    logic [7:0]                cnt;
    logic [BLK_BITS-1:0]       offset;
    logic [VDNUM-1:0]          mounted;
    logic [VDNUM-1:0]          ro_tab;
    logic [VDNUM-1:0][63:0]    size_tab;
    logic [VDNUM-1:0]          drv_hot;
    logic [7:0]                din_sel;
    logic                      last;

    // Descending scan so the lowest requesting drive is the one left standing.
    always_comb begin
        arb_hit = 1'b0;
        arb     = '0;
        drv_hot = '0;
        din_sel = '0;
        for (int i = VDNUM - 1; i >= 0; i--) begin
            if (sd_rd[i] || sd_wr[i]) begin
                arb_hit   = 1'b1;
                arb.drv   = 4'(i);
                arb.lba   = sd_lba_flat[32*i +: 32];
                arb.rd    = sd_rd[i];
                arb.valid = mounted[i] &&
                            ((({32'd0, sd_lba_flat[32*i +: 32]} + 64'd1) << BLK_BITS) <= size_tab[i]);
                arb.ro    = ro_tab[i];
            end
        end
        for (int i = 0; i < VDNUM; i++) begin
            if (cur.drv == 4'(i)) begin
                drv_hot[i] = 1'b1;
                din_sel    = sd_buff_din_flat[8*i +: 8];
            end
        end
    end

    assign last         = &offset;
    assign sd_buff_addr = offset;
    assign mem_addr     = {cur.lba, offset};
    assign mem_drive    = cur.drv;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            cur          <= '0;
            cnt          <= '0;
            offset       <= '0;
            sd_ack       <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
        end else begin
            sd_buff_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        cur    <= arb;
                        cnt    <= '0;
                        offset <= '0;
                        state  <= ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (cnt == 8'(ACK_DELAY - 1)) begin
                        sd_ack <= drv_hot;
                        state  <= cur.rd ? RD_FETCH : WR_ADDR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RD_FETCH: begin
                    if (!cur.valid) begin
                        sd_buff_dout <= 8'h00;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUSH;
                    end else if (!mem_req) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                    end else if (mem_ready) begin
                        mem_req      <= 1'b0;
                        sd_buff_dout <= mem_rdata;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUSH;
                    end
                end
                RD_PUSH: begin
                    offset <= offset + 1'b1;
                    state  <= last ? DONE : RD_FETCH;
                end
                // Client buffer has one cycle of read latency: present address, then sample.
                WR_ADDR:   state <= WR_SAMPLE;
                WR_SAMPLE: begin
                    mem_wdata <= din_sel;
                    state     <= WR_STORE;
                end
                WR_STORE: begin
                    if (!cur.valid || cur.ro) begin
                        offset <= offset + 1'b1;
                        state  <= last ? DONE : WR_ADDR;
                    end else if (!mem_req) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end else if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        offset  <= offset + 1'b1;
                        state   <= last ? DONE : WR_ADDR;
                    end
                end
                DONE: begin
                    sd_ack <= '0;
                    cnt    <= '0;
                    state  <= (GAP == 0) ? IDLE : GAP_WAIT;
                end
                GAP_WAIT: begin
                    if (cnt == 8'(GAP - 1)) state <= IDLE;
                    else                    cnt   <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mount path runs independently of the transfer FSM; out-of-range drives match no entry.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mounted      <= '0;
            ro_tab       <= '0;
            size_tab     <= '0;
            img_mounted  <= '0;
            img_size     <= '0;
            img_readonly <= 1'b0;
        end else begin
            img_mounted <= '0;
            for (int i = 0; i < VDNUM; i++) begin
                if (mount_stb && mount_drive == 4'(i)) begin
                    size_tab[i]    <= mount_size;
                    ro_tab[i]      <= mount_ro;
                    mounted[i]     <= |mount_size;
                    img_mounted[i] <= 1'b1;
                    img_size       <= mount_size;
                    img_readonly   <= mount_ro;
                end
            end
        end
    end

`ifdef SD_TRACE_EN
    logic [31:0] trc_cyc;
    logic [31:0] trc_xfers;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            trc_cyc   <= '0;
            trc_xfers <= '0;
        end else begin
            trc_cyc <= trc_cyc + 32'd1;
            if (state == IDLE && arb_hit) begin
                trc_cyc   <= '0;
                trc_xfers <= trc_xfers + 32'd1;
            end
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk_sys) begin
        if (!reset && state == IDLE && arb_hit)
            $display("SDSRV: drv=%0d lba=%0d %s valid=%0d xfer=%0d",
                     arb.drv, arb.lba, arb.rd ? "rd" : "wr", arb.valid, trc_xfers + 32'd1);
        if (!reset && state == DONE)
            $display("SDSRV: done drv=%0d cycles=%0d xfer=%0d", cur.drv, trc_cyc, trc_xfers);
    end
`endif
`endif

endmodule

// File: tb/tb_sd_block_server.sv
// Scoreboard bench for sd_block_server: expected bytes/writes queued at request time, popped as the DUT produces them.
module tb_sd_block_server;
    localparam int VDNUM = 3, BLK_BITS = 9, ACK_DELAY = 4, GAP = 2, NB = 512, LIMIT = 20000;

    logic                   clk_sys = 1'b0;
    logic                   reset = 1'b1;
    logic [32*VDNUM-1:0]    sd_lba_flat = '0;
    logic [VDNUM-1:0]       sd_rd = '0, sd_wr = '0, sd_ack, img_mounted;
    logic [BLK_BITS-1:0]    sd_buff_addr;
    logic [7:0]             sd_buff_dout, mem_wdata, mem_rdata;
    logic                   sd_buff_wr, img_readonly, mem_req, mem_we, mem_ready;
    logic [8*VDNUM-1:0]     sd_buff_din_flat;
    logic [63:0]            img_size, mount_size = '0;
    logic                   mount_stb = 1'b0, mount_ro = 1'b0;
    logic [3:0]             mount_drive = '0, mem_drive;
    logic [32+BLK_BITS-1:0] mem_addr;

    always #5 clk_sys = ~clk_sys;

    sd_block_server #(.VDNUM(VDNUM), .BLK_BITS(BLK_BITS), .ACK_DELAY(ACK_DELAY), .GAP(GAP)) dut (
        .clk_sys(clk_sys), .reset(reset), .sd_lba_flat(sd_lba_flat), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din_flat(sd_buff_din_flat), .img_mounted(img_mounted), .img_size(img_size),
        .img_readonly(img_readonly), .mount_stb(mount_stb), .mount_drive(mount_drive),
        .mount_size(mount_size), .mount_ro(mount_ro), .mem_req(mem_req), .mem_we(mem_we),
        .mem_drive(mem_drive), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready));

    int checks = 0, errors = 0;
    int rd_seen = 0, n_acc = 0, rd_extra = 0, ra_extra = 0, wr_extra = 0, ack_viol = 0;
    logic [63:0] rd_q[$], ra_q[$], wr_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Memory: mem_ready pulses 2 cycles after mem_req rises, read data = addr[7:0].
    initial begin
        int cnt;
        cnt = 0; mem_ready = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk_sys); #1;
            if (reset || mem_ready) begin
                mem_ready = 1'b0; cnt = 0;
            end else if (mem_req) begin
                cnt++;
                if (cnt == 2) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_addr[7:0];
                    n_acc++;
                    if (mem_we) begin
                        if (wr_q.size() == 0) wr_extra++;
                        else chk("wr_beat", 64'({mem_drive, mem_addr, mem_wdata}), wr_q.pop_front());
                    end else begin
                        if (ra_q.size() == 0) ra_extra++;
                        else chk("rd_addr", 64'(mem_addr), ra_q.pop_front());
                    end
                end
            end
        end
    end

    // Client buffer with one cycle of read latency; content is ~offset for every drive.
    initial begin
        logic [BLK_BITS-1:0] a;
        sd_buff_din_flat = '0;
        forever begin
            @(negedge clk_sys); a = sd_buff_addr;
            @(posedge clk_sys); #1;
            sd_buff_din_flat = {VDNUM{~a[7:0]}};
        end
    end

    always @(negedge clk_sys) begin
        if ($countones(sd_ack) > 1) ack_viol++;
        if (!reset && sd_buff_wr) begin
            rd_seen++;
            if (rd_q.size() == 0) rd_extra++;
            else chk("rd_beat", 64'({sd_buff_addr, sd_buff_dout}), rd_q.pop_front());
        end
    end

    task automatic wait_ack(input int b, input logic lvl, output int n);
        n = 0;
        while (sd_ack[b] !== lvl && n < LIMIT) begin
            @(negedge clk_sys); n++;
        end
        if (n >= LIMIT) chk("ack_wait", 64'(sd_ack[b]), 64'(lvl));
    endtask

    task automatic expect_xfer(input int d, input logic rd, input logic [31:0] lba, input bit mem_ok);
        for (int o = 0; o < NB; o++) begin
            logic [8:0] oo;
            oo = 9'(o);
            if (rd) begin
                rd_q.push_back(64'({oo, mem_ok ? oo[7:0] : 8'h00}));
                if (mem_ok) ra_q.push_back(64'({lba, oo}));
            end else if (mem_ok) begin
                wr_q.push_back(64'({4'(d), lba, oo, ~oo[7:0]}));
            end
        end
    endtask

    task automatic mount(input logic [3:0] d, input logic [63:0] sz, input logic ro, input logic [2:0] exp_pulse);
        @(negedge clk_sys);
        mount_stb = 1'b1; mount_drive = d; mount_size = sz; mount_ro = ro;
        @(negedge clk_sys);
        mount_stb = 1'b0;
        chk("mnt_pulse", 64'(img_mounted), 64'(exp_pulse));
        if (exp_pulse != 0) begin
            chk("mnt_size", img_size, sz);
            chk("mnt_ro", 64'(img_readonly), 64'(ro));
        end
        @(negedge clk_sys);
        chk("mnt_pulse_end", 64'(img_mounted), 64'd0);
    endtask

    task automatic xfer(input int d, input logic rd, input logic [31:0] lba, input bit mem_ok);
        int n, s_acc, s_seen;
        expect_xfer(d, rd, lba, mem_ok);
        s_acc = n_acc; s_seen = rd_seen;
        @(negedge clk_sys);
        sd_lba_flat[32*d +: 32] = lba;
        if (rd) sd_rd[d] = 1'b1; else sd_wr[d] = 1'b1;
        wait_ack(d, 1'b1, n);
        // The first counted edge is the accept edge itself.
        chk("ack_lat", 64'(n), 64'(ACK_DELAY + 1));
        sd_rd[d] = 1'b0; sd_wr[d] = 1'b0;
        wait_ack(d, 1'b0, n);
        @(negedge clk_sys);
        chk("q_left", 64'(rd_q.size() + ra_q.size() + wr_q.size()), 64'd0);
        chk("mem_acc", 64'(n_acc - s_acc), mem_ok ? 64'(NB) : 64'd0);
        if (rd) chk("rd_beats", 64'(rd_seen - s_seen), 64'(NB));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_ack", 64'(sd_ack), 64'd0);
        chk("rst_mreq", 64'(mem_req), 64'd0);
        chk("rst_bwr", 64'(sd_buff_wr), 64'd0);
        chk("rst_mnt", 64'(img_mounted), 64'd0);
        chk("rst_size", img_size, 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);

        mount(4'd0, 64'd143360, 1'b0, 3'b001);
        mount(4'd3, 64'd4096, 1'b1, 3'b000);
        mount(4'd9, 64'd4096, 1'b1, 3'b000);
        mount(4'd1, 64'd1 << 20, 1'b0, 3'b010);

        xfer(0, 1'b1, 32'd5, 1'b1);
        xfer(1, 1'b0, 32'd3, 1'b1);

        // Same-cycle requests: drive0 read first, drive2 write after the gap.
        mount(4'd2, 64'd143360, 1'b0, 3'b100);
        expect_xfer(0, 1'b1, 32'd10, 1'b1);
        expect_xfer(2, 1'b0, 32'd2, 1'b1);
        s = n_acc;
        @(negedge clk_sys);
        sd_lba_flat[31:0] = 32'd10; sd_lba_flat[95:64] = 32'd2;
        sd_rd[0] = 1'b1; sd_wr[2] = 1'b1;
        wait_ack(0, 1'b1, n);
        chk("prio_first", 64'(sd_ack), 64'd1);
        sd_rd[0] = 1'b0;
        wait_ack(0, 1'b0, n);
        wait_ack(2, 1'b1, n);
        chk("gap_lat", 64'(n), 64'(GAP + ACK_DELAY + 1));
        chk("prio_second", 64'(sd_ack), 64'd4);
        sd_wr[2] = 1'b0;
        wait_ack(2, 1'b0, n);
        @(negedge clk_sys);
        chk("prio_q_left", 64'(rd_q.size() + ra_q.size() + wr_q.size()), 64'd0);
        chk("prio_acc", 64'(n_acc - s), 64'(2 * NB));

        mount(4'd2, 64'd143360, 1'b1, 3'b100);
        xfer(2, 1'b0, 32'd0, 1'b0);
        xfer(0, 1'b1, 32'd279, 1'b1);
        xfer(0, 1'b1, 32'd280, 1'b0);

        // Reset in the middle of a read, then repeat the same block.
        expect_xfer(0, 1'b1, 32'd7, 1'b1);
        @(negedge clk_sys);
        sd_lba_flat[31:0] = 32'd7; sd_rd[0] = 1'b1;
        wait_ack(0, 1'b1, n);
        sd_rd[0] = 1'b0;
        s = rd_seen;
        n = 0;
        while (rd_seen - s < 100 && n < LIMIT) begin
            @(posedge clk_sys); #2; n++;
        end
        chk("rst_reach100", 64'(rd_seen - s >= 100), 64'd1);
        reset = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("midrst_ack", 64'(sd_ack), 64'd0);
        chk("midrst_mreq", 64'(mem_req), 64'd0);
        chk("midrst_bwr", 64'(sd_buff_wr), 64'd0);
        reset = 1'b0;
        rd_q.delete(); ra_q.delete(); wr_q.delete();
        mount(4'd0, 64'd143360, 1'b0, 3'b001);
        xfer(0, 1'b1, 32'd7, 1'b1);

        chk("ack_onehot", 64'(ack_viol), 64'd0);
        chk("rd_extra", 64'(rd_extra), 64'd0);
        chk("ra_extra", 64'(ra_extra), 64'd0);
        chk("wr_extra", 64'(wr_extra), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
